// File: rtl/npu_conv_mac_engine.sv
// npu_conv_mac_engine: host-driven K_H x K_W window dot-product engine with ReLU, saturation and channel accumulate
module npu_conv_mac_engine #(
   parameter int K_H   = 3,
   parameter int K_W   = 3,
   parameter int DW    = 8,
   parameter int ACC_W = 24
) (
   input  logic        clk,
   input  logic        rst_ni,
   input  logic        ena,
   input  logic        wea,
   input  logic [15:0] addra,
   input  logic [31:0] dina,
   output logic [31:0] douta,
   output logic        irq_o
);
   localparam int CSW = 2 * DW + $clog2(K_H) + 1;
   localparam int SW  = (CSW > ACC_W ? CSW : ACC_W) + 1;
   localparam int CW  = K_W > 1 ? $clog2(K_W) : 1;

   if (K_H < 1 || K_H * DW > 32) begin : g_bad_kh
      $error("npu_conv_mac_engine: K_H*DW must be 1..32 bits");
   end
   if (K_W < 1 || K_W > 15) begin : g_bad_kw
      $error("npu_conv_mac_engine: K_W must be 1..15");
   end
   if (ACC_W <= 2 * DW || ACC_W > 32) begin : g_bad_acc
      $error("npu_conv_mac_engine: need 2*DW < ACC_W <= 32");
   end

   typedef enum logic [1:0] {IDLE, RUN, POST} state_t;

   state_t                  state, state_nxt;
   logic                    busy, run, post;
   logic [CW-1:0]           col;
   logic signed [DW-1:0]    pix [K_W][K_H];
   logic signed [DW-1:0]    wgt [K_W][K_H];
   logic signed [ACC_W-1:0] acc, acc_nxt, result;
   logic signed [CSW-1:0]   col_sum;
   logic signed [SW-1:0]    sum;
   logic                    pos_ovf, neg_ovf;
   logic [31:0]             count, rd_data;
   logic                    relu_en, accum_mode, done, sat, err;
   logic [3:0]              sel;
   logic                    wr, rd, wr_ctrl, wr_pix, wr_wgt, wr_cfg;
   logic                    start, acc_clr, win_clr, flg_clr, pix_wr, wgt_ok, wgt_wr, cfg_wr, bad;
   logic [CW-1:0]           widx;
   logic                    unused_bits;

   assign sel         = addra[3:0];
   assign widx        = addra[4 +: CW];
   assign unused_bits = ^{addra[15:8], dina};
   assign wr          = ena & wea;
   assign rd          = ena & ~wea;
   assign wr_ctrl     = wr && sel == 4'h0;
   assign wr_pix      = wr && sel == 4'h1;
   assign wr_wgt      = wr && sel == 4'h2;
   assign wr_cfg      = wr && sel == 4'h3;
   assign start       = wr_ctrl & dina[0] & ~busy;
   assign acc_clr     = wr_ctrl & dina[1] & ~busy;
   assign win_clr     = wr_ctrl & dina[2] & ~busy;
   assign flg_clr     = wr_ctrl & dina[3] & ~busy;
   assign pix_wr      = wr_pix & ~busy;
   assign wgt_ok      = addra[7:4] < 4'(K_W);
   assign wgt_wr      = wr_wgt & ~busy & wgt_ok;
   assign cfg_wr      = wr_cfg & ~busy;
   // every host write except reads is refused while a dot product is in flight
   assign bad         = busy ? (wr_pix | wr_wgt | wr_cfg | (wr_ctrl & |dina[3:0])) : (wr_wgt & ~wgt_ok);

   always_ff @(posedge clk) begin
      if (!rst_ni) state <= IDLE;
      else state <= state_nxt;
   end

   always_comb begin
      state_nxt = IDLE;
      if (state == IDLE) state_nxt = start ? RUN : IDLE;
      else if (state == RUN) state_nxt = col == CW'(K_W - 1) ? POST : RUN;
   end

   always_comb begin
      busy = state != IDLE;
      run  = state == RUN;
      post = state == POST;
   end

   // column sum is wide enough that only the accumulator add can overflow
   always_comb begin
      col_sum = '0;
      for (int r = 0; r < K_H; r++) col_sum = col_sum + CSW'(pix[col][r]) * CSW'(wgt[col][r]);
      sum     = SW'(acc) + SW'(col_sum);
      pos_ovf = !sum[SW-1] && |sum[SW-2:ACC_W-1];
      neg_ovf = sum[SW-1] && !(&sum[SW-2:ACC_W-1]);
      acc_nxt = pos_ovf ? {1'b0, {(ACC_W-1){1'b1}}} : neg_ovf ? {1'b1, {(ACC_W-1){1'b0}}} : sum[ACC_W-1:0];
   end

   always_comb rd_data = sel == 4'h0 ? {28'd0, err, sat, done, busy} : sel == 4'h1 ? 32'(result) : sel == 4'h2 ? count : '0;

   always_ff @(posedge clk) begin
      if (!rst_ni || win_clr) pix <= '{default: '0};
      else if (pix_wr) begin
         for (int c = 0; c < K_W - 1; c++) pix[c] <= pix[c + 1];
         for (int r = 0; r < K_H; r++) pix[K_W - 1][r] <= dina[r*DW +: DW];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_ni) wgt <= '{default: '0};
      else if (wgt_wr) for (int r = 0; r < K_H; r++) wgt[widx][r] <= dina[r*DW +: DW];
   end

   always_ff @(posedge clk) begin
      if (!rst_ni) begin
         col        <= '0;
         acc        <= '0;
         result     <= '0;
         count      <= '0;
         relu_en    <= 1'b0;
         accum_mode <= 1'b0;
         done       <= 1'b0;
         sat        <= 1'b0;
         err        <= 1'b0;
         irq_o      <= 1'b0;
         douta      <= '0;
      end else begin
         col   <= run ? col + CW'(1) : '0;
         acc   <= run ? acc_nxt : (acc_clr || (start && !accum_mode)) ? '0 : acc;
         sat   <= (flg_clr || start) ? 1'b0 : (run && (pos_ovf || neg_ovf)) ? 1'b1 : sat;
         done  <= (flg_clr || start) ? 1'b0 : post ? 1'b1 : done;
         err   <= flg_clr ? 1'b0 : bad ? 1'b1 : err;
         irq_o <= post;
         if (post) begin
            result <= (relu_en && acc[ACC_W-1]) ? '0 : acc;
            count  <= count + 32'd1;
         end
         if (cfg_wr) {accum_mode, relu_en} <= dina[1:0];
         if (rd) douta <= rd_data;
      end
   end
endmodule

// File: tb/tb_npu_conv_mac_engine.sv
// tb_npu_conv_mac_engine: scoreboard bench with an arithmetic reference model of the conv MAC engine
module tb_npu_conv_mac_engine;
   // ACC_W=17 is the narrowest legal width for DW=8, so saturation is reachable with 3x3 windows
   localparam int K_H = 3, K_W = 3, DW = 8, ACC_W = 17;

   logic        clk = 1'b0, rst_ni = 1'b0, ena = 1'b0, wea = 1'b0;
   logic [15:0] addra = '0;
   logic [31:0] dina = '0;
   logic [31:0] douta;
   logic        irq_o;

   int          checks = 0, errors = 0, cyc = 0;
   logic        rd_d = 1'b0, fin = 1'b0;
   logic [31:0] exp_rd [$];
   string       exp_nm [$];
   int          exp_irq [$];
   logic [31:0] mon_e;
   string       mon_n;
   int          mon_c;

   int          mpix [K_W][K_H];
   int          mw [K_W][K_H];
   longint      macc = 0;
   int          mres = 0, mcount = 0, p_res = 0;
   bit          mdone, msat, merr, mbusy, relu, accm, p_sat;

   npu_conv_mac_engine #(.K_H(K_H), .K_W(K_W), .DW(DW), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst_ni(rst_ni), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      rd_d <= ena & ~wea;
   end

   always @(negedge clk) begin
      if (rd_d) begin
         checks++;
         if (exp_rd.size() == 0) begin
            errors++;
            $display("FAIL read_extra got %h want none", douta);
         end else begin
            mon_e = exp_rd.pop_front();
            mon_n = exp_nm.pop_front();
            if (douta !== mon_e) begin
               errors++;
               $display("FAIL %s got %h want %h", mon_n, douta, mon_e);
            end
         end
      end
      if (irq_o) begin
         checks++;
         if (exp_irq.size() == 0) begin
            errors++;
            $display("FAIL irq_unexpected got irq at cycle %0d want none", cyc);
         end else begin
            mon_c = exp_irq.pop_front();
            if (cyc != mon_c) begin
               errors++;
               $display("FAIL irq_time got cycle %0d want %0d", cyc, mon_c);
            end
         end
      end
      if (fin) begin
         checks++;
         if (exp_irq.size() != 0 || exp_rd.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d irq %0d reads pending want 0 0", exp_irq.size(), exp_rd.size());
         end
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   function automatic logic [31:0] pk(input int a, input int b, input int c);
      return {8'h0, 8'(c), 8'(b), 8'(a)};
   endfunction

   function automatic void run_model();
      longint hi = (longint'(1) << (ACC_W - 1)) - 1;
      longint lo = -(longint'(1) << (ACC_W - 1));
      longint s;
      p_sat = 1'b0;
      for (int c = 0; c < K_W; c++) begin
         s = 0;
         for (int r = 0; r < K_H; r++) s += longint'(mpix[c][r] * mw[c][r]);
         macc += s;
         if (macc > hi) begin macc = hi; p_sat = 1'b1; end
         else if (macc < lo) begin macc = lo; p_sat = 1'b1; end
      end
      p_res = (relu && macc < 0) ? 0 : int'(macc);
   endfunction

   function automatic void model_reset();
      mpix = '{default: 0};
      mw = '{default: 0};
      macc = 0; mres = 0; mcount = 0;
      {mdone, msat, merr, mbusy, relu, accm} = '0;
   endfunction

   function automatic void model_wr(input logic [3:0] a, input int idx, input logic [31:0] d);
      if (mbusy) begin
         if (a inside {4'h1, 4'h2, 4'h3} || (a == 4'h0 && d[3:0] != 4'h0)) merr = 1'b1;
         return;
      end
      case (a)
         4'h0: begin
            if (d[3]) {mdone, msat, merr} = '0;
            if (d[2]) mpix = '{default: 0};
            if (d[1]) macc = 0;
            if (d[0]) begin
               if (!accm) macc = 0;
               run_model();
               {mbusy, mdone, msat} = 3'b100;
               exp_irq.push_back(cyc + K_W + 2);
            end
         end
         4'h1: begin
            for (int c = 0; c < K_W - 1; c++) mpix[c] = mpix[c + 1];
            for (int r = 0; r < K_H; r++) mpix[K_W - 1][r] = int'($signed(d[r*DW +: DW]));
         end
         4'h2: if (idx < K_W) for (int r = 0; r < K_H; r++) mw[idx][r] = int'($signed(d[r*DW +: DW]));
               else merr = 1'b1;
         4'h3: {accm, relu} = d[1:0];
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] model_rd(input logic [3:0] a);
      case (a)
         4'h0: return {28'd0, merr, msat, mdone, mbusy};
         4'h1: return 32'(mres);
         4'h2: return 32'(mcount);
         default: return 32'd0;
      endcase
   endfunction

   task automatic wr(input logic [3:0] a, input int idx, input logic [31:0] d);
      ena = 1'b1; wea = 1'b1; addra = {8'h0, 4'(idx), a}; dina = d;
      model_wr(a, idx, d);
      @(posedge clk); #1;
      ena = 1'b0; wea = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, input string n);
      ena = 1'b1; wea = 1'b0; addra = {12'h0, a};
      exp_rd.push_back(model_rd(a));
      exp_nm.push_back(n);
      @(posedge clk); #1;
      ena = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (irq_o) break;
      end
      {mbusy, mdone, msat} = {1'b0, 1'b1, p_sat};
      mres = p_res;
      mcount++;
   endtask

   task automatic fill(input int p, input int w);
      for (int c = 0; c < K_W; c++) wr(4'h1, 0, pk(p, p, p));
      for (int c = 0; c < K_W; c++) wr(4'h2, c, pk(w, w, w));
   endtask

   task automatic go(input string n);
      wr(4'h0, 0, 32'h1);
      wait_done();
      rd(4'h1, n);
      rd(4'h0, {n, "_status"});
   endtask

   int v;

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_ni = 1'b1;
      rd(4'h0, "rst_status"); rd(4'h1, "rst_result"); rd(4'h2, "rst_count");

      fill(1, 1);
      go("ones_9");
      rd(4'h2, "ones_count");

      fill(1, -1);
      go("neg_9");
      wr(4'h3, 0, 32'h1);
      go("relu_0");
      wr(4'h3, 0, 32'h2);
      go("acc_kept_m18");

      fill(1, 2);
      wr(4'h0, 0, 32'h2);
      go("accum_18");
      go("accum_36");
      wr(4'h0, 0, 32'h3);
      go("clear_start_18");
      wr(4'h3, 0, 32'h0);

      fill(127, 127);
      go("sat_pos");
      fill(-128, 127);
      go("sat_neg");
      wr(4'h0, 0, 32'h8);
      rd(4'h0, "flag_clear_status");

      for (int i = 1; i <= 4; i++) wr(4'h1, 0, pk(i, i, i));
      wr(4'h2, 0, pk(1, 1, 1)); wr(4'h2, 1, 32'h0); wr(4'h2, 2, 32'h0);
      go("window_shift_6");
      wr(4'h2, 5, pk(9, 9, 9));
      rd(4'h0, "bad_wgt_idx_status");
      wr(4'h0, 0, 32'h8);

      fill(1, 1);
      wr(4'h0, 0, 32'h1);
      wr(4'h1, 0, pk(5, 5, 5));
      wr(4'h0, 0, 32'h1);
      rd(4'h1, "busy_result");
      rd(4'h0, "busy_status");
      wait_done();
      rd(4'h1, "after_busy_result");
      rd(4'h0, "after_busy_status");
      go("window_untouched_9");

      wr(4'h0, 0, 32'h1);
      @(posedge clk); #1;
      rst_ni = 1'b0;
      model_reset();
      exp_irq.delete();
      repeat (2) @(posedge clk);
      #1 rst_ni = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      rd(4'h0, "abort_status"); rd(4'h1, "abort_result"); rd(4'h2, "abort_count");

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: begin
               v = $urandom_range(0, 1) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 6)) - 3;
               wr(4'h1, 0, pk(v, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 255)) - 128));
            end
            3, 4: wr(4'h2, $urandom_range(0, 3), $urandom);
            5: wr(4'h3, 0, 32'($urandom_range(0, 3)));
            6: begin
               wr(4'h0, 0, 32'($urandom_range(0, 7)) << 1);
               rd(4'h0, "rnd_ctrl_status");
            end
            default: begin
               wr(4'h0, 0, 32'h1 | (32'($urandom_range(0, 1)) << 1));
               wait_done();
               rd(4'h1, "rnd_result");
               rd(4'h0, "rnd_status");
               rd(4'h2, "rnd_count");
            end
         endcase
      end
      rd(4'h7, "unmapped_addr");
      fin = 1'b1;
      repeat (5) @(posedge clk);
      $display("FAIL no_finish got running want finished");
      $fatal(1);
   end
endmodule
